// File: rtl/chaining_scoreboard.sv
// RAW chaining scoreboard for the vector lane: tracks in-flight writer records and answers
// per-port operand-read hazard checks with a registered result.
module chaining_scoreboard #(
    parameter int NR_RECORDS    = 4,
    parameter int NR_READ_PORTS = 2,
    parameter int VS_LO_BITS    = 3,
    parameter int OFFSET_BITS   = 3,
    parameter int INST_BITS     = 3
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          alloc_valid,
    output logic                                          alloc_ready,
    input  logic                                          alloc_vd_valid,
    input  logic [VS_LO_BITS+1:0]                         alloc_vd,
    input  logic [INST_BITS-1:0]                          alloc_inst,
    input  logic                                          wb_valid,
    input  logic [INST_BITS-1:0]                          wb_inst,
    input  logic [2**(VS_LO_BITS+OFFSET_BITS)-1:0]        wb_mask,
    input  logic                                          retire_valid,
    input  logic [INST_BITS-1:0]                          retire_inst,
    input  logic [NR_READ_PORTS-1:0]                      rd_valid,
    input  logic [NR_READ_PORTS*(VS_LO_BITS+2)-1:0]       rd_vs,
    input  logic [NR_READ_PORTS*OFFSET_BITS-1:0]          rd_offset,
    input  logic [NR_READ_PORTS*INST_BITS-1:0]            rd_inst,
    output logic [NR_READ_PORTS-1:0]                      rd_resp_valid,
    output logic [NR_READ_PORTS-1:0]                      rd_ok,
    output logic [$clog2(NR_RECORDS+1)-1:0]               occupancy
);
    localparam int VS_W   = VS_LO_BITS + 2;
    localparam int IDX_W  = VS_LO_BITS + OFFSET_BITS;
    localparam int MASK_W = 2**IDX_W;
    localparam int OCC_W  = $clog2(NR_RECORDS + 1);

    logic [NR_RECORDS-1:0] recValid;
    logic [NR_RECORDS-1:0] recVdValid;
    logic [VS_W-1:0]       recVd   [NR_RECORDS];
    logic [INST_BITS-1:0]  recInst [NR_RECORDS];
    logic [MASK_W-1:0]     recMask [NR_RECORDS];

    logic [NR_RECORDS-1:0]    allocHit;
    logic                     allocFound;
    logic                     allocFire;
    logic [NR_RECORDS-1:0]    validNext;
    logic [OCC_W-1:0]         occNext;
    logic [NR_READ_PORTS-1:0] okNext;

    // Mask bit i covers element (i mod 2**OFFSET_BITS) of vreg vd+(i >> OFFSET_BITS), so a
    // record whose base is not group-aligned spills into the next group (hitVd1).
    function automatic logic recHazard(
        input logic                  valid,
        input logic                  vdValid,
        input logic [VS_W-1:0]       vd,
        input logic [INST_BITS-1:0]  inst,
        input logic [MASK_W-1:0]     mask,
        input logic [VS_W-1:0]       vs,
        input logic [OFFSET_BITS-1:0] off,
        input logic [INST_BITS-1:0]  rInst
    );
        logic                sameInst;
        logic                older;
        logic                hitVd;
        logic                hitVd1;
        logic [IDX_W-1:0]    readIdx;
        logic [IDX_W-1:0]    shiftAmt;
        logic [MASK_W-1:0]   readOh;
        logic [3*MASK_W-1:0] padded;
        logic [2*MASK_W-1:0] window;
        sameInst = (rInst == inst);
        older    = sameInst | ((rInst[INST_BITS-2:0] < inst[INST_BITS-2:0])
                               ^ rInst[INST_BITS-1] ^ inst[INST_BITS-1]);
        readIdx  = {vs[VS_LO_BITS-1:0], off};
        readOh   = MASK_W'(1) << readIdx;
        shiftAmt = {vd[VS_LO_BITS-1:0], {OFFSET_BITS{1'b0}}};
        padded   = {{MASK_W{1'b1}}, mask, {MASK_W{1'b1}}} << shiftAmt;
        window   = padded[3*MASK_W-1:MASK_W];
        hitVd    = ((readOh & window[MASK_W-1:0]) == '0)
                   && (vs[VS_W-1 -: 2] == vd[VS_W-1 -: 2]);
        hitVd1   = ((readOh & window[2*MASK_W-1:MASK_W]) == '0)
                   && (vs[VS_W-1 -: 2] == 2'(vd[VS_W-1 -: 2] + 2'd1));
        return valid & vdValid & ~sameInst & ~older & (hitVd | hitVd1);
    endfunction

    assign alloc_ready = ~&recValid;
    assign allocFire   = alloc_valid & alloc_ready;

    always_comb begin
        allocHit   = '0;
        allocFound = 1'b0;
        for (int i = 0; i < NR_RECORDS; i++) begin
            if (!recValid[i] && !allocFound) begin
                allocHit[i] = 1'b1;
                allocFound  = 1'b1;
            end
        end
    end

    // Alloc only targets slots free at the start of the cycle, so a slot retired this
    // cycle is never reused until the next one.
    always_comb begin
        validNext = recValid;
        occNext   = '0;
        for (int i = 0; i < NR_RECORDS; i++) begin
            if (recValid[i] && retire_valid && recInst[i] == retire_inst) validNext[i] = 1'b0;
            if (allocFire && allocHit[i]) validNext[i] = 1'b1;
            occNext = occNext + OCC_W'(validNext[i]);
        end
    end

    always_comb begin
        okNext = '1;
        for (int p = 0; p < NR_READ_PORTS; p++) begin
            for (int r = 0; r < NR_RECORDS; r++) begin
                if (recHazard(recValid[r], recVdValid[r], recVd[r], recInst[r], recMask[r],
                              rd_vs[p*VS_W +: VS_W],
                              rd_offset[p*OFFSET_BITS +: OFFSET_BITS],
                              rd_inst[p*INST_BITS +: INST_BITS])) begin
                    okNext[p] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            recValid      <= '0;
            recVdValid    <= '0;
            occupancy     <= '0;
            rd_resp_valid <= '0;
            rd_ok         <= '1;
            for (int i = 0; i < NR_RECORDS; i++) begin
                recVd[i]   <= '0;
                recInst[i] <= '0;
                recMask[i] <= '0;
            end
        end else begin
            recValid  <= validNext;
            occupancy <= occNext;
            for (int i = 0; i < NR_RECORDS; i++) begin
                if (allocFire && allocHit[i]) begin
                    recVd[i]      <= alloc_vd;
                    recVdValid[i] <= alloc_vd_valid;
                    recInst[i]    <= alloc_inst;
                    recMask[i]    <= '0;
                end else if (recValid[i] && wb_valid && recInst[i] == wb_inst) begin
                    recMask[i] <= recMask[i] | wb_mask;
                end
            end
            rd_resp_valid <= rd_valid;
            for (int p = 0; p < NR_READ_PORTS; p++) begin
                if (rd_valid[p]) rd_ok[p] <= okNext[p];
            end
        end
    end
endmodule

// File: tb/tb_chaining_scoreboard.sv
// Directed bench for chaining_scoreboard: read expectations are queued at issue and
// checked by a monitor whenever a response strobe appears.
module tb_chaining_scoreboard;
    logic        clock = 1'b0;
    logic        reset;
    logic        alloc_valid, alloc_ready, alloc_vd_valid;
    logic [4:0]  alloc_vd;
    logic [2:0]  alloc_inst;
    logic        wb_valid;
    logic [2:0]  wb_inst;
    logic [63:0] wb_mask;
    logic        retire_valid;
    logic [2:0]  retire_inst;
    logic [1:0]  rd_valid;
    logic [9:0]  rd_vs;
    logic [5:0]  rd_offset;
    logic [5:0]  rd_inst;
    logic [1:0]  rd_resp_valid, rd_ok;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;
    logic expQ0[$];
    logic expQ1[$];

    chaining_scoreboard dut (
        .clock(clock), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_vd_valid(alloc_vd_valid), .alloc_vd(alloc_vd), .alloc_inst(alloc_inst),
        .wb_valid(wb_valid), .wb_inst(wb_inst), .wb_mask(wb_mask),
        .retire_valid(retire_valid), .retire_inst(retire_inst),
        .rd_valid(rd_valid), .rd_vs(rd_vs), .rd_offset(rd_offset), .rd_inst(rd_inst),
        .rd_resp_valid(rd_resp_valid), .rd_ok(rd_ok), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    // Monitor: compare each response strobe with the oldest queued expectation.
    always @(negedge clock) begin
        if (rd_resp_valid[0]) begin
            checks++;
            if (expQ0.size() == 0) begin
                errors++;
                $display("FAIL port0 unexpected response: rd_ok=%0b", rd_ok[0]);
            end else begin
                logic e0;
                e0 = expQ0.pop_front();
                if (rd_ok[0] !== e0) begin
                    errors++;
                    $display("FAIL port0 rd_ok at %0t: got %0b expected %0b", $time, rd_ok[0], e0);
                end
            end
        end
        if (rd_resp_valid[1]) begin
            checks++;
            if (expQ1.size() == 0) begin
                errors++;
                $display("FAIL port1 unexpected response: rd_ok=%0b", rd_ok[1]);
            end else begin
                logic e1;
                e1 = expQ1.pop_front();
                if (rd_ok[1] !== e1) begin
                    errors++;
                    $display("FAIL port1 rd_ok at %0t: got %0b expected %0b", $time, rd_ok[1], e1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic doAlloc(input logic [4:0] vd, input logic [2:0] inst);
        alloc_valid = 1'b1; alloc_vd_valid = 1'b1; alloc_vd = vd; alloc_inst = inst;
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic doWb(input logic [2:0] inst, input logic [63:0] mask);
        wb_valid = 1'b1; wb_inst = inst; wb_mask = mask;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic doRetire(input logic [2:0] inst);
        retire_valid = 1'b1; retire_inst = inst;
        step();
        retire_valid = 1'b0;
    endtask

    task automatic readPorts(input logic [4:0] vs0, input logic [2:0] off0, input logic [2:0] inst0,
                             input logic exp0, input logic [4:0] vs1, input logic [2:0] off1,
                             input logic [2:0] inst1, input logic exp1);
        rd_valid = 2'b11; rd_vs = {vs1, vs0}; rd_offset = {off1, off0}; rd_inst = {inst1, inst0};
        expQ0.push_back(exp0);
        expQ1.push_back(exp1);
        step();
        rd_valid = 2'b00;
    endtask

    task automatic readBoth(input logic [4:0] vs, input logic [2:0] off, input logic [2:0] inst,
                            input logic exp);
        readPorts(vs, off, inst, exp, vs, off, inst, exp);
    endtask

    task automatic drain(input string name);
        step();
        checkVal(name, 8'(expQ0.size() + expQ1.size()), 8'd0);
        expQ0.delete();
        expQ1.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; alloc_valid = 1'b0; alloc_vd_valid = 1'b0; alloc_vd = '0; alloc_inst = '0;
        wb_valid = 1'b0; wb_inst = '0; wb_mask = '0; retire_valid = 1'b0; retire_inst = '0;
        rd_valid = '0; rd_vs = '0; rd_offset = '0; rd_inst = '0;
        repeat (2) step();
        reset = 1'b0;

        // Reset state and empty-table reads
        checkVal("reset occupancy", 8'(occupancy), 8'd0);
        checkVal("reset alloc_ready", 8'(alloc_ready), 8'd1);
        checkVal("reset rd_ok", 8'(rd_ok), 8'h3);
        checkVal("reset rd_resp_valid", 8'(rd_resp_valid), 8'h0);
        readBoth(5'd8, 3'd0, 3'd1, 1'b1);
        drain("t1 drain");

        // Basic RAW hazard, wb to an absent inst, then clearing by write-back
        doAlloc(5'd8, 3'd2);
        checkVal("t2 occupancy", 8'(occupancy), 8'd1);
        readPorts(5'd8, 3'd3, 3'd3, 1'b0, 5'd8, 3'd3, 3'd1, 1'b1);
        doWb(3'd3, 64'h8);
        readBoth(5'd8, 3'd3, 3'd3, 1'b0);
        doWb(3'd2, 64'h8);
        readBoth(5'd8, 3'd3, 3'd3, 1'b1);
        readPorts(5'd8, 3'd4, 3'd3, 1'b0, 5'd9, 3'd3, 3'd3, 1'b0);
        doRetire(3'd2);
        checkVal("t2 occupancy after retire", 8'(occupancy), 8'd0);
        drain("t2 drain");

        // Group spill: base vreg 14 covers vregs 14..21 (next group up to vs=21)
        doAlloc(5'd14, 3'd2);
        readBoth(5'd16, 3'd0, 3'd3, 1'b0);
        readPorts(5'd22, 3'd0, 3'd3, 1'b1, 5'd24, 3'd0, 3'd3, 1'b1);
        readPorts(5'd14, 3'd0, 3'd3, 1'b0, 5'd13, 3'd7, 3'd3, 1'b1);
        doWb(3'd2, 64'h1_0000);
        readPorts(5'd16, 3'd0, 3'd3, 1'b1, 5'd16, 3'd1, 3'd3, 1'b0);
        doRetire(3'd2);
        drain("t3 drain");

        // Wrap-aware age, duplicate alloc
        doAlloc(5'd8, 3'd7);
        readPorts(5'd8, 3'd0, 3'd0, 1'b0, 5'd8, 3'd0, 3'd6, 1'b1);
        readPorts(5'd8, 3'd0, 3'd7, 1'b1, 5'd8, 3'd0, 3'd1, 1'b0);
        doAlloc(5'd8, 3'd7);
        checkVal("t4 duplicate occupancy", 8'(occupancy), 8'd2);
        doRetire(3'd7);
        checkVal("t4 occupancy after retire", 8'(occupancy), 8'd0);
        drain("t4 drain");

        // Full table; retire and alloc in the same cycle
        for (int i = 0; i < 4; i++) doAlloc(5'd0, 3'(i));
        checkVal("t5 full occupancy", 8'(occupancy), 8'd4);
        checkVal("t5 full alloc_ready", 8'(alloc_ready), 8'd0);
        alloc_valid = 1'b1; alloc_vd_valid = 1'b1; alloc_vd = 5'd1; alloc_inst = 3'd4;
        retire_valid = 1'b1; retire_inst = 3'd1;
        step();
        retire_valid = 1'b0;
        checkVal("t5 occupancy after retire", 8'(occupancy), 8'd3);
        checkVal("t5 alloc_ready after retire", 8'(alloc_ready), 8'd1);
        step();
        alloc_valid = 1'b0;
        checkVal("t5 occupancy after late alloc", 8'(occupancy), 8'd4);
        checkVal("t5 alloc_ready refilled", 8'(alloc_ready), 8'd0);
        doRetire(3'd0);
        doRetire(3'd2);
        doRetire(3'd3);
        doRetire(3'd4);
        checkVal("t5 occupancy emptied", 8'(occupancy), 8'd0);

        // wb+retire same cycle, rd_ok hold, reset with a pending read
        doAlloc(5'd8, 3'd5);
        doAlloc(5'd16, 3'd6);
        checkVal("t6 occupancy", 8'(occupancy), 8'd2);
        wb_valid = 1'b1; wb_inst = 3'd5; wb_mask = '1;
        retire_valid = 1'b1; retire_inst = 3'd5;
        step();
        wb_valid = 1'b0; retire_valid = 1'b0;
        checkVal("t6 occupancy after wb+retire", 8'(occupancy), 8'd1);
        readBoth(5'd8, 3'd0, 3'd7, 1'b1);
        readBoth(5'd16, 3'd0, 3'd7, 1'b0);
        step();
        checkVal("t6 rd_ok hold", 8'(rd_ok), 8'h0);
        checkVal("t6 resp_valid idle", 8'(rd_resp_valid), 8'h0);
        drain("t6 drain");
        rd_valid = 2'b11; rd_vs = {5'd16, 5'd16}; rd_offset = '0; rd_inst = {3'd7, 3'd7};
        reset = 1'b1;
        step();
        reset = 1'b0; rd_valid = 2'b00;
        checkVal("t6 reset resp_valid", 8'(rd_resp_valid), 8'h0);
        checkVal("t6 reset rd_ok", 8'(rd_ok), 8'h3);
        checkVal("t6 reset occupancy", 8'(occupancy), 8'd0);
        readBoth(5'd16, 3'd0, 3'd7, 1'b1);
        drain("t6 final drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
